fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 8-bit core, directly upstream of the decoder. It owns the program counter and issues single-outstanding byte reads to instruction memory. It presents one instruction per transaction to the decoder on `instr`/`force_nop`. For the load-next opcode (8'h80) it fetches the following immediate byte before presenting, and it handles control-flow redirects, including discarding in-flight reads.

## Interface
- `PC_WIDTH`, 8: program counter and instruction address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request; held high until `imem_valid`.
- `imem_addr`  out  PC_WIDTH  read address; stable while `imem_req` high.
- `imem_valid`  in  1  read data valid, one-cycle pulse per request.
- `imem_data`  in  8  read data.
- `stall`  in  1  decoder/downstream cannot accept this cycle.
- `redirect`  in  1  jump taken; load `redirect_pc`.
- `redirect_pc`  in  PC_WIDTH  jump target.
- `instr`  out  8  instruction byte to decoder.
- `force_nop`  out  1  high when `instr` is not a valid instruction this cycle.
- `imm`  out  8  immediate byte accompanying an 8'h80 instruction.
- `instr_pc`  out  PC_WIDTH  address of presented instruction.

## Operation
- States: IDLE, FETCH, FETCH_IMM, PRESENT, DRAIN.
- Reset values:
  - Registers: state=IDLE, pc=RESET_PC, instr=8'h00, imm=8'h00, instr_pc=RESET_PC.
  - Outputs: imem_req=0, force_nop=1.
- IDLE → FETCH unconditionally next cycle. `imem_valid` is ignored in IDLE. Instruction memory shares `rst` and drops pending reads.
- FETCH:
  - Drives imem_req=1, imem_addr=pc.
  - On imem_valid with data≠8'h80: instr←data, instr_pc←pc, pc←pc+1, go to PRESENT.
  - On imem_valid with data=8'h80: instr←8'h80, instr_pc←pc, pc←pc+1, go to FETCH_IMM.
- FETCH_IMM:
  - Drives imem_req=1, imem_addr=pc.
  - On imem_valid: imm←data, pc←pc+1, go to PRESENT.
- PRESENT:
  - force_nop=0, imem_req=0.
  - If !stall, the instruction is consumed this cycle; go to FETCH.
  - If stall, hold instr/imm/instr_pc unchanged.
- `force_nop` = (state≠PRESENT). `instr` retains its last value while force_nop=1.
- PC arithmetic is modulo 2^PC_WIDTH. 8'h80 at the max address takes its immediate from address 0.
- Redirect has priority over everything except `rst`. On `redirect`=1 in any state: pc←redirect_pc, and the presented instruction, if any, is dropped, not consumed. Next state depends on the current state:
  - FETCH/FETCH_IMM with imem_valid=0 → DRAIN (read still outstanding).
  - FETCH/FETCH_IMM with imem_valid=1 → FETCH; the returned data is discarded.
  - PRESENT or IDLE → FETCH.
  - DRAIN → stay in DRAIN; pc takes the newest target.
- DRAIN: imem_req=0. Wait for imem_valid, discard the data, then go to FETCH. A redirect in the same cycle as the drain completes updates pc and still goes to FETCH.
- `stall` has no effect outside PRESENT.

## Timing
- Minimum latency, zero-wait memory (imem_valid the cycle after req rises):
  - Plain instruction: 2 cycles FETCH→PRESENT.
  - 8'h80 instruction: 4 cycles.
- Maximum throughput: one plain instruction per 3 cycles (FETCH, data return, PRESENT).
- All outputs are registered or decoded from state only. There is no combinational path from `stall` or `redirect` to any output.
- `imem_addr` may change only in a cycle where imem_req=0 or imem_valid=1.

## Test plan
- Reset, then memory returns 8'h12 at addr 0 with one-cycle latency → force_nop=1 until PRESENT; then instr=8'h12, instr_pc=0, force_nop=0; next fetch at addr 1.
- Mem[5]=8'h80, mem[6]=8'h3C, start pc=5 → instr=8'h80, imm=8'h3C, instr_pc=5 presented once; next fetch at addr 7.
- Present 8'hA1 with stall high 4 cycles → instr held, force_nop=0 throughout, no imem_req; fetch resumes the cycle after stall drops.
- Redirect to 8'h40 while FETCH read outstanding, memory returns 8'hFF three cycles later → 8'hFF never presented; next imem_addr=8'h40.
- PC_WIDTH=8, 8'h80 at 8'hFF, mem[0]=8'h07 → imm=8'h07, next fetch at addr 1.
- Redirect and stall asserted together in PRESENT → instruction dropped, force_nop=1 next cycle, fetch from the redirect target.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory read port, decoder-side controls and
// the presented instruction. master = fetch unit, slave = memory/decoder side.
interface fetch_if #(
    parameter int PC_WIDTH = 8
) ();
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid;
    logic [7:0]          imem_data;
    logic                stall;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [7:0]          instr;
    logic                force_nop;
    logic [7:0]          imm;
    logic [PC_WIDTH-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr, force_nop, imm, instr_pc,
        input  imem_valid, imem_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, force_nop, imm, instr_pc,
        output imem_valid, imem_data, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding byte reads and
// presents one instruction (with its immediate for 8'h80) per transaction.
module fetch_unit #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    localparam logic [7:0] OP_LOAD_NEXT = 8'h80;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        FETCH_IMM = 3'd2,
        PRESENT   = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    state_t              state_r, state_next_s;
    logic [PC_WIDTH-1:0] pc_r, pc_next_s;
    logic [PC_WIDTH-1:0] instr_pc_r, instr_pc_next_s;
    logic [7:0]          instr_r, instr_next_s;
    logic [7:0]          imm_r, imm_next_s;
    logic [PC_WIDTH-1:0] pc_inc_s;

    assign pc_inc_s = pc_r + PC_WIDTH'(1);

    // Next-state and datapath updates; a redirect overrides all normal progress.
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        instr_next_s    = instr_r;
        imm_next_s      = imm_r;
        instr_pc_next_s = instr_pc_r;
        if (bus.redirect) begin
            // A read still in flight must be waited out in DRAIN; its data is never used.
            pc_next_s = bus.redirect_pc;
            case (state_r)
                FETCH, FETCH_IMM, DRAIN: state_next_s = bus.imem_valid ? FETCH : DRAIN;
                default:                 state_next_s = FETCH;
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    state_next_s = FETCH;
                end
                FETCH: begin
                    if (bus.imem_valid) begin
                        instr_next_s    = bus.imem_data;
                        instr_pc_next_s = pc_r;
                        pc_next_s       = pc_inc_s;
                        state_next_s    = (bus.imem_data == OP_LOAD_NEXT) ? FETCH_IMM : PRESENT;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
                FETCH_IMM: begin
                    if (bus.imem_valid) begin
                        imm_next_s   = bus.imem_data;
                        pc_next_s    = pc_inc_s;
                        state_next_s = PRESENT;
                    end else begin
                        state_next_s = FETCH_IMM;
                    end
                end
                PRESENT: begin
                    state_next_s = bus.stall ? PRESENT : FETCH;
                end
                DRAIN: begin
                    state_next_s = bus.imem_valid ? FETCH : DRAIN;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= 8'h00;
            imm_r      <= 8'h00;
            instr_pc_r <= RESET_PC;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            instr_r    <= instr_next_s;
            imm_r      <= imm_next_s;
            instr_pc_r <= instr_pc_next_s;
        end
    end

    // Outputs come straight from registers or a decode of the state register.
    assign bus.imem_req  = (state_r == FETCH) || (state_r == FETCH_IMM);
    assign bus.imem_addr = pc_r;
    assign bus.force_nop = (state_r != PRESENT);
    assign bus.instr     = instr_r;
    assign bus.imm       = imm_r;
    assign bus.instr_pc  = instr_pc_r;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then a
// randomized run against a transaction-level model and a latency-randomized memory.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.PC_WIDTH(8)) bus ();

    fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    // stimulus requested for the next cycle
    bit         drv_rst, drv_stall, drv_redirect;
    logic [7:0] drv_rpc;
    int         lat_fixed;
    bit         rand_mode, checking;

    // memory responder
    bit         mem_busy;
    int         mem_cnt;
    logic [7:0] mem_addr;

    // reference model: where the fetch is, what is being presented
    bit         m_started, m_pres, m_stale, m_want_imm;
    logic [7:0] m_pc, m_instr, m_imm, m_ipc;

    // outputs sampled in the current cycle
    logic       s_req, s_nop;
    logic [7:0] s_addr, s_instr, s_imm, s_ipc;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = m_started && !m_pres && !m_stale;
        chk("imem_req", {7'd0, s_req}, {7'd0, exp_req});
        if (exp_req) chk("imem_addr", s_addr, m_pc);
        chk("force_nop", {7'd0, s_nop}, {7'd0, !m_pres});
        chk("instr", s_instr, m_instr);
        chk("imm", s_imm, m_imm);
        chk("instr_pc", s_ipc, m_ipc);
    endtask

    task automatic model_update(input bit r, input bit v, input logic [7:0] d,
                                input bit st, input bit rd, input logic [7:0] rpc);
        if (r) begin
            m_started = 1'b0; m_pres = 1'b0; m_stale = 1'b0; m_want_imm = 1'b0;
            m_pc = 8'h00; m_instr = 8'h00; m_imm = 8'h00; m_ipc = 8'h00;
        end else if (!m_started) begin
            m_started = 1'b1;
            if (rd) m_pc = rpc;
        end else if (m_pres) begin
            if (rd) begin
                m_pres = 1'b0;
                m_pc   = rpc;
            end else if (!st) begin
                m_pres = 1'b0;
            end
        end else if (m_stale) begin
            if (v) m_stale = 1'b0;
            if (rd) m_pc = rpc;
        end else begin
            if (rd) begin
                m_pc       = rpc;
                m_want_imm = 1'b0;
                if (!v) m_stale = 1'b1;
            end else if (v) begin
                if (m_want_imm) begin
                    m_imm      = d;
                    m_pc       = m_pc + 8'd1;
                    m_want_imm = 1'b0;
                    m_pres     = 1'b1;
                end else begin
                    m_instr = d;
                    m_ipc   = m_pc;
                    m_pc    = m_pc + 8'd1;
                    if (d == 8'h80) m_want_imm = 1'b1;
                    else            m_pres     = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        logic       v;
        logic [7:0] d;
        @(negedge clk);
        s_req = bus.imem_req;   s_addr  = bus.imem_addr; s_nop = bus.force_nop;
        s_instr = bus.instr;    s_imm   = bus.imm;       s_ipc = bus.instr_pc;
        if (checking) check_outputs();
        checking = 1'b1;
        v = 1'b0;
        d = 8'($urandom);
        if (drv_rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                v = 1'b1;
                d = mem[mem_addr];
                mem_busy = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (bus.imem_req === 1'b1) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_addr;
            mem_cnt  = ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3))) - 1;
        end else if (rand_mode && !m_started && $urandom_range(0, 1) == 1) begin
            v = 1'b1;  // stray pulse while idle must be ignored
        end
        rst             = drv_rst;
        bus.imem_valid  = v;
        bus.imem_data   = d;
        bus.stall       = drv_stall;
        bus.redirect    = drv_redirect;
        bus.redirect_pc = drv_rpc;
        @(posedge clk);
        model_update(drv_rst, v, d, drv_stall, drv_redirect, drv_rpc);
    endtask

    task automatic do_reset();
        drv_rst = 1'b1; drv_stall = 1'b0; drv_redirect = 1'b0; drv_rpc = 8'h00;
        step();
        step();
        drv_rst = 1'b0;
    endtask

    initial begin
        bus.imem_valid = 1'b0; bus.imem_data = 8'h00; bus.stall = 1'b0;
        bus.redirect = 1'b0;   bus.redirect_pc = 8'h00;
        checking = 1'b0; rand_mode = 1'b0; mem_busy = 1'b0; mem_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // plain instruction, one-cycle memory
        lat_fixed = 1; mem[0] = 8'h12;
        do_reset();
        step(); chk("t1_idle_nop", {7'd0, s_nop}, 8'd1); chk("t1_idle_req", {7'd0, s_req}, 8'd0);
        step(); chk("t1_req", {7'd0, s_req}, 8'd1); chk("t1_addr", s_addr, 8'h00);
        step(); chk("t1_wait_nop", {7'd0, s_nop}, 8'd1);
        step(); chk("t1_nop", {7'd0, s_nop}, 8'd0); chk("t1_instr", s_instr, 8'h12);
                chk("t1_ipc", s_ipc, 8'h00);
        step(); chk("t1_next_addr", s_addr, 8'h01); chk("t1_next_req", {7'd0, s_req}, 8'd1);

        // load-next with immediate, starting at pc 5
        mem[5] = 8'h80; mem[6] = 8'h3C;
        do_reset();
        drv_redirect = 1'b1; drv_rpc = 8'h05;
        step();
        drv_redirect = 1'b0;
        step(); chk("t2_addr", s_addr, 8'h05);
        step();
        step(); chk("t2_imm_addr", s_addr, 8'h06); chk("t2_imm_nop", {7'd0, s_nop}, 8'd1);
        step();
        step(); chk("t2_nop", {7'd0, s_nop}, 8'd0); chk("t2_instr", s_instr, 8'h80);
                chk("t2_imm", s_imm, 8'h3C); chk("t2_ipc", s_ipc, 8'h05);
        step(); chk("t2_once", {7'd0, s_nop}, 8'd1); chk("t2_next_addr", s_addr, 8'h07);

        // held presentation under stall
        mem[0] = 8'hA1;
        do_reset();
        step(); step(); step();
        drv_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_nop", {7'd0, s_nop}, 8'd0); chk("t3_instr", s_instr, 8'hA1);
            chk("t3_req", {7'd0, s_req}, 8'd0);
        end
        drv_stall = 1'b0;
        step(); chk("t3_last_nop", {7'd0, s_nop}, 8'd0);
        step(); chk("t3_resume_req", {7'd0, s_req}, 8'd1); chk("t3_resume_addr", s_addr, 8'h01);

        // redirect with a slow read outstanding
        lat_fixed = 3; mem[0] = 8'hFF;
        do_reset();
        step(); step();
        drv_redirect = 1'b1; drv_rpc = 8'h40;
        step();
        drv_redirect = 1'b0;
        step(); chk("t4_drain_req", {7'd0, s_req}, 8'd0); chk("t4_drain_nop", {7'd0, s_nop}, 8'd1);
        step(); chk("t4_drain2_nop", {7'd0, s_nop}, 8'd1);
        step(); chk("t4_req", {7'd0, s_req}, 8'd1); chk("t4_addr", s_addr, 8'h40);
                chk("t4_nop", {7'd0, s_nop}, 8'd1);

        // load-next at the top address wraps to 0 for its immediate
        lat_fixed = 1; mem[8'hFF] = 8'h80; mem[0] = 8'h07;
        do_reset();
        drv_redirect = 1'b1; drv_rpc = 8'hFF;
        step();
        drv_redirect = 1'b0;
        step(); chk("t5_addr", s_addr, 8'hFF);
        step();
        step(); chk("t5_imm_addr", s_addr, 8'h00);
        step();
        step(); chk("t5_imm", s_imm, 8'h07); chk("t5_ipc", s_ipc, 8'hFF);
        step(); chk("t5_next_addr", s_addr, 8'h01);

        // redirect and stall together while presenting
        mem[0] = 8'hA1;
        do_reset();
        step(); step(); step();
        drv_stall = 1'b1; drv_redirect = 1'b1; drv_rpc = 8'h20;
        step(); chk("t6_pres_nop", {7'd0, s_nop}, 8'd0);
        drv_stall = 1'b0; drv_redirect = 1'b0;
        step(); chk("t6_nop", {7'd0, s_nop}, 8'd1); chk("t6_req", {7'd0, s_req}, 8'd1);
                chk("t6_addr", s_addr, 8'h20);

        // randomized run against the model
        rand_mode = 1'b1; lat_fixed = 0;
        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            drv_rst      = ($urandom_range(0, 299) == 0);
            drv_stall    = ($urandom_range(0, 2) == 0);
            drv_redirect = ($urandom_range(0, 19) == 0);
            drv_rpc      = 8'($urandom);
            step();
        end
        drv_rst = 1'b0; drv_stall = 1'b0; drv_redirect = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
